// File: rtl/wide_ser_pkg.sv
// Shared types and elaboration-time helpers for the wide sum serializer.
// Optional reduction outputs are enabled by defining WIDE_SER_REDUCE_EN.
package wide_ser_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Ceiling log2, never below 1 so a single-beat configuration still has an index bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return (r == 0) ? 1 : r;
   endfunction

   // Number of CHUNK-wide beats needed to carry WIDTH bits.
   function automatic int unsigned nchunk_calc(input int unsigned width, input int unsigned chunk);
      return (width + chunk - 1) / chunk;
   endfunction

endpackage

// File: rtl/wide_reduce.sv
// Combinational AND/OR reduction over the raw sum bits (no padding).
// Only instantiated when WIDE_SER_REDUCE_EN is defined.
module wide_reduce #(
   parameter int unsigned WIDTH = 100
)(
   input  logic [WIDTH-1:0] i_data,
   output logic             o_all,
   output logic             o_any
);

   assign o_all = &i_data;
   assign o_any = |i_data;

endmodule

// File: rtl/wide_sum_serializer.sv
// Captures a WIDTH-bit sum and streams it out LSB chunk first as CHUNK-bit beats.
// Define WIDE_SER_REDUCE_EN to add the per-sum out_all_ones / out_any_one flags.
module wide_sum_serializer
   import wide_ser_pkg::*;
#(
   parameter  int unsigned WIDTH  = 100,
   parameter  int unsigned CHUNK  = 16,
   localparam int unsigned NCHUNK = nchunk_calc(WIDTH, CHUNK),
   localparam int unsigned IDXW   = clog2_min1(NCHUNK)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CHUNK-1:0] out_data,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_last
`ifdef WIDE_SER_REDUCE_EN
   ,
   output logic             out_all_ones,
   output logic             out_any_one
`endif
);

   localparam int unsigned     SHW      = NCHUNK * CHUNK;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SHW-1:0]   r_shadow;
   logic [IDXW-1:0]  r_idx;
   logic [IDXW-1:0]  w_idx_nxt;
   logic             w_send;
   logic             w_last;
   logic             w_in_ready;
   logic             w_load;
   logic [CHUNK-1:0] w_chunk;

   assign w_send     = (r_state == SEND);
   assign w_last     = w_send && (r_idx == LAST_IDX);
   // A new sum is taken while idle, or in the same cycle the final beat leaves.
   assign w_in_ready = !w_send || (w_last && out_ready);
   assign w_load     = in_valid && w_in_ready;

   // Next-state and beat-index sequencing.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      unique case (r_state)
         IDLE: begin
            if (w_load) begin
               w_state_nxt = SEND;
               w_idx_nxt   = '0;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (w_last) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = w_load ? SEND : IDLE;
               end else begin
                  w_idx_nxt = r_idx + IDXW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // State and beat index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Shadow copy of the sum, zero-extended so the last beat's padding reads as 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
      end else if (w_load) begin
         r_shadow <= SHW'(in_data);
      end
   end

   // Select the chunk addressed by the current beat index.
   always_comb begin
      w_chunk = '0;
      for (int unsigned k = 0; k < NCHUNK; k++) begin
         if (r_idx == IDXW'(k)) begin
            w_chunk = r_shadow[k*CHUNK +: CHUNK];
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_send;
   assign out_data  = w_send ? w_chunk : '0;
   assign out_idx   = r_idx;
   assign out_last  = w_last;

`ifdef WIDE_SER_REDUCE_EN
   logic w_all;
   logic w_any;
   logic r_all_ones;
   logic r_any_one;

   wide_reduce #(
      .WIDTH (WIDTH)
   ) u_reduce (
      .i_data (in_data),
      .o_all  (w_all),
      .o_any  (w_any)
   );

   // Flags follow the sum being sent and clear when the serializer goes idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_all_ones <= 1'b0;
         r_any_one  <= 1'b0;
      end else if (w_load) begin
         r_all_ones <= w_all;
         r_any_one  <= w_any;
      end else if (w_state_nxt == IDLE) begin
         r_all_ones <= 1'b0;
         r_any_one  <= 1'b0;
      end
   end

   assign out_all_ones = r_all_ones;
   assign out_any_one  = r_any_one;
`endif

endmodule

// File: tb/tb_wide_sum_serializer.sv
// Self-checking bench for wide_sum_serializer (default WIDTH=100, CHUNK=16).
// Build with WIDE_SER_REDUCE_EN defined to also check the reduction flags.
module tb_wide_sum_serializer;

   localparam int W  = 100;
   localparam int C  = 16;
   localparam int NB = (W + C - 1) / C;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [C-1:0]  out_data;
   logic [2:0]    out_idx;
   logic          out_last;
`ifdef WIDE_SER_REDUCE_EN
   logic          out_all_ones;
   logic          out_any_one;
`endif

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   wide_sum_serializer #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last)
`ifdef WIDE_SER_REDUCE_EN
      ,
      .out_all_ones (out_all_ones),
      .out_any_one  (out_any_one)
`endif
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   // Reference model: a queue of the beats still owed to the consumer.
   typedef struct packed {
      logic [C-1:0] d;
      logic [2:0]   idx;
      logic         last;
      logic         all1;
      logic         any1;
   } beat_t;
   beat_t q[$];

   function automatic void push_sum(input logic [W-1:0] d);
      logic [NB*C-1:0] z;
      beat_t b;
      z = {{(NB*C-W){1'b0}}, d};
      for (int k = 0; k < NB; k++) begin
         b.d    = C'(z >> (C*k));
         b.idx  = 3'(k);
         b.last = (k == NB-1);
         b.all1 = &d;
         b.any1 = |d;
         q.push_back(b);
      end
   endfunction

   function automatic logic model_ready();
      return (q.size() == 0) || (q[0].last && out_ready);
   endfunction

   always @(negedge rst_n) q.delete();

   // Compare every cycle's outputs with the model, away from the clock edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("mon_in_ready", 128'(in_ready), 128'(model_ready()));
         chk("mon_valid", 128'(out_valid), 128'(q.size() != 0));
         if (q.size() != 0) begin
            chk("mon_data", 128'(out_data), 128'(q[0].d));
            chk("mon_idx",  128'(out_idx),  128'(q[0].idx));
            chk("mon_last", 128'(out_last), 128'(q[0].last));
`ifdef WIDE_SER_REDUCE_EN
            chk("mon_all1", 128'(out_all_ones), 128'(q[0].all1));
            chk("mon_any1", 128'(out_any_one),  128'(q[0].any1));
         end else begin
            chk("mon_all1_idle", 128'(out_all_ones), 128'(0));
            chk("mon_any1_idle", 128'(out_any_one),  128'(0));
`endif
         end
      end
   end

   // Advance the model on each edge: retire an accepted beat, then queue any captured sum.
   always @(posedge clk) begin
      logic cap;
      if (rst_n) begin
         cap = in_valid && model_ready();
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (cap) push_sum(in_data);
      end
   end

   task automatic drv(input logic v, input logic [W-1:0] d, input logic r);
      @(posedge clk); #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
   endtask

   function automatic logic [W-1:0] rnd100();
      return W'({$urandom, $urandom, $urandom, $urandom});
   endfunction

   typedef struct packed {
      logic [W-1:0]      d;
      logic [NB-1:0][C-1:0] b;
   } vec_t;

   initial begin
      vec_t       tbl [5];
      int         nv;
      int         acc;
      logic       v_neg;
      logic [C-1:0] bp_exp;
      logic [C-1:0] b7;
      logic [2:0]   i7;
      logic [W-1:0] all_ones;

      all_ones = '1;
      tbl[0] = {100'd3,                            112'h0000_0000_0000_0000_0000_0000_0003};
      tbl[1] = {100'hffff_ffff_ffff_ffff,          112'h0000_0000_0000_ffff_ffff_ffff_ffff};
      tbl[2] = {all_ones,                          112'h000f_ffff_ffff_ffff_ffff_ffff_ffff};
      tbl[3] = {100'h7,                            112'h0000_0000_0000_0000_0000_0000_0007};
      tbl[4] = {100'h1_2345_6789_abcd_ef01_2345_6789, 112'h0001_2345_6789_abcd_ef01_2345_6789};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #1;
      chk("rst_valid",    128'(out_valid), 128'(0));
      chk("rst_in_ready", 128'(in_ready),  128'(1));
      chk("rst_data",     128'(out_data),  128'(0));
      chk("rst_idx",      128'(out_idx),   128'(0));
      chk("rst_last",     128'(out_last),  128'(0));
      #11 rst_n = 1'b1;

      // Table-driven single sums with no backpressure; in_data goes X once captured.
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, tbl[i].d, 1'b1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_data  = 'x;
         for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            chk("tbl_data", 128'(out_data), 128'(tbl[i].b[k]));
            chk("tbl_idx",  128'(out_idx),  128'(k));
            chk("tbl_last", 128'(out_last), 128'(k == NB-1));
`ifdef WIDE_SER_REDUCE_EN
            chk("tbl_all1", 128'(out_all_ones), 128'(i == 2));
            chk("tbl_any1", 128'(out_any_one),  128'(1));
`endif
         end
         @(negedge clk);
         chk("tbl_idle_ready", 128'(in_ready),  128'(1));
         chk("tbl_idle_valid", 128'(out_valid), 128'(0));
      end

      // Back-to-back sums: 14 valid beats with no bubble, second sum starts at beat 7.
      drv(1'b1, 100'h1, 1'b1);
      @(posedge clk); #1;
      in_data = 100'hbeef;
      nv = 0; b7 = '0; i7 = '1;
      for (int k = 0; k < 2*NB; k++) begin
         @(negedge clk);
         if (out_valid) nv++;
         if (k == NB) begin b7 = out_data; i7 = out_idx; end
         if (k == NB-1) begin @(posedge clk); #1; in_valid = 1'b0; end
      end
      chk("b2b_valid_beats", 128'(nv), 128'(2*NB));
      chk("b2b_beat7_data",  128'(b7), 128'(16'hbeef));
      chk("b2b_beat7_idx",   128'(i7), 128'(0));

      // Alternating backpressure with in_data churning after capture.
      drv(1'b1, 100'h12345678, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = rnd100(); out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 40 && acc < NB; c++) begin
         @(negedge clk);
         v_neg = out_valid;
         bp_exp = (acc == 0) ? 16'h5678 : (acc == 1) ? 16'h1234 : 16'h0000;
         chk("bp_data", 128'(out_data), 128'(bp_exp));
         chk("bp_idx",  128'(out_idx),  128'(acc));
         @(posedge clk);
         if (v_neg && out_ready) acc++;
         #1;
         out_ready = !out_ready;
         in_data   = rnd100();
      end
      chk("bp_beats", 128'(acc), 128'(NB));
      out_ready = 1'b1;

      // Reset asserted mid-sum, then a fresh sum starts from index 0.
      drv(1'b1, 100'habc_def0_1234_5678_9abc, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid && out_idx == 3'd3) break;
      end
      chk("rst_mid_reached_idx3", 128'(out_idx), 128'(3));
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid",    128'(out_valid), 128'(0));
      chk("rst_mid_in_ready", 128'(in_ready),  128'(1));
      chk("rst_mid_data",     128'(out_data),  128'(0));
      chk("rst_mid_idx",      128'(out_idx),   128'(0));
      chk("rst_mid_last",     128'(out_last),  128'(0));
      @(posedge clk); #2 rst_n = 1'b1;
      drv(1'b1, 100'h7, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", 128'(out_valid), 128'(1));
      chk("post_rst_data",  128'(out_data),  128'(16'h0007));
      chk("post_rst_idx",   128'(out_idx),   128'(0));
      repeat (NB) @(posedge clk);

      // Randomized traffic checked by the queue model.
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom % 2) != 0;
         out_ready = ($urandom % 4) != 0;
         case ($urandom % 4)
            0:       in_data = '1;
            1:       in_data = '0;
            default: in_data = rnd100();
         endcase
      end

      // Drain with a bounded wait.
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 3*NB && out_valid; c++) @(negedge clk);
      @(negedge clk);
      chk("drain_idle", 128'(out_valid), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
